// File: rtl/sdram_ctrl.sv
// rtl/sdram_ctrl.sv - closed-page SDR SDRAM controller for a x16 device
// SDRAM_REQ_QUEUE_EN: one-entry pending buffer for a req arriving while busy.
module sdram_ctrl #(
   parameter int ROW_BITS       = 12,
   parameter int COL_BITS       = 8,
   parameter int BANK_BITS      = 2,
   parameter int CAS_LATENCY    = 2,
   parameter int T_RP           = 2,
   parameter int T_RCD          = 2,
   parameter int T_RFC          = 7,
   parameter int T_WR           = 2,
   parameter int INIT_CYCLES    = 20000,
   parameter int REFRESH_CYCLES = 750
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   refresh,
   input  logic                                   req,
   input  logic                                   we,
   input  logic [ROW_BITS+BANK_BITS+COL_BITS-1:0] address,
   input  logic [1:0]                             wm,
   input  logic [15:0]                            data_write,
   output logic [15:0]                            data_read,
   output logic                                   ack,
   output logic                                   busy,
   output logic                                   init_done,
   output logic                                   sdram_cke,
   output logic                                   sdram_cs_n,
   output logic                                   sdram_ras_n,
   output logic                                   sdram_cas_n,
   output logic                                   sdram_we_n,
   output logic [BANK_BITS-1:0]                   sdram_ba,
   output logic [ROW_BITS-1:0]                    sdram_a,
   output logic [1:0]                             sdram_dqm,
   inout  wire  [15:0]                            sdram_dq
);

   localparam int ADDR_BITS = ROW_BITS + BANK_BITS + COL_BITS;
   localparam int CNT_W = $clog2(INIT_CYCLES + T_RFC + T_WR + T_RP + T_RCD + CAS_LATENCY + 1);
   localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
   localparam logic [REF_W-1:0] REF_MAX = {REF_W{1'b1}};
   localparam logic [ROW_BITS-1:0] MODE_WORD = ROW_BITS'(512 + (CAS_LATENCY << 4));

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP   = 4'b1111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_MRS   = 4'b0000;

   typedef enum logic [3:0] {
      INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
      IDLE, ACT, RW, RD_WAIT, WR_REC, REF_WAIT
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [3:0]           cmd_q, cmd_n;
   logic [BANK_BITS-1:0] ba_q, ba_n;
   logic [ROW_BITS-1:0]  a_q, a_n;
   logic [1:0]           dqm_q, dqm_n;
   logic                 cke_q;
   logic                 dq_oe, dq_oe_n;
   logic [15:0]          dq_out;
   logic                 ack_n, rd_cap, done_set, ref_issue;
   logic                 start_new, start_pend, pend_load;
   logic [REF_W-1:0]     ref_cnt;
   logic                 force_ref;

   logic                 cur_we;
   logic [COL_BITS-1:0]  cur_col;
   logic [1:0]           cur_wm;
   logic [15:0]          cur_data;

   logic                 pend_valid;
   logic                 pend_we;
   logic [ADDR_BITS-1:0] pend_addr;
   logic [1:0]           pend_wm;
   logic [15:0]          pend_data;

   logic [ADDR_BITS-1:0] sel_addr;
   logic                 sel_we;
   logic [1:0]           sel_wm;
   logic [15:0]          sel_data;
   logic [ROW_BITS-1:0]  sel_row;
   logic [BANK_BITS-1:0] sel_bank;
   logic [COL_BITS-1:0]  sel_col;

   // A buffered request always outranks a fresh one.
   assign sel_addr  = pend_valid ? pend_addr : address;
   assign sel_we    = pend_valid ? pend_we   : we;
   assign sel_wm    = pend_valid ? pend_wm   : wm;
   assign sel_data  = pend_valid ? pend_data : data_write;
   assign sel_row   = sel_addr[ADDR_BITS-1 -: ROW_BITS];
   assign sel_bank  = sel_addr[COL_BITS +: BANK_BITS];
   assign sel_col   = sel_addr[COL_BITS-1:0];
   assign force_ref = (ref_cnt >= REF_W'(REFRESH_CYCLES));

   always_comb begin
      state_n    = state;
      cnt_n      = (cnt == '0) ? '0 : cnt - 1'b1;
      cmd_n      = CMD_NOP;
      ba_n       = ba_q;
      a_n        = a_q;
      dqm_n      = dqm_q;
      dq_oe_n    = 1'b0;
      ack_n      = 1'b0;
      rd_cap     = 1'b0;
      done_set   = 1'b0;
      ref_issue  = 1'b0;
      start_new  = 1'b0;
      start_pend = 1'b0;
      case (state)
         INIT_WAIT: if (cnt == '0) begin
            cmd_n   = CMD_PRE;
            ba_n    = '0;
            a_n     = '0;
            a_n[10] = 1'b1;
            cnt_n   = CNT_W'(T_RP - 1);
            state_n = INIT_PRE;
         end
         INIT_PRE: if (cnt == '0) begin
            cmd_n   = CMD_REF;
            cnt_n   = CNT_W'(T_RFC - 1);
            state_n = INIT_REF1;
         end
         INIT_REF1: if (cnt == '0) begin
            cmd_n   = CMD_REF;
            cnt_n   = CNT_W'(T_RFC - 1);
            state_n = INIT_REF2;
         end
         INIT_REF2: if (cnt == '0) begin
            cmd_n   = CMD_MRS;
            ba_n    = '0;
            a_n     = MODE_WORD;
            cnt_n   = CNT_W'(1);
            state_n = INIT_MRS;
         end
         INIT_MRS: if (cnt == '0) begin
            done_set = 1'b1;
            state_n  = IDLE;
         end
         IDLE: begin
            if (force_ref || (!pend_valid && !req && refresh)) begin
               cmd_n     = CMD_REF;
               ref_issue = 1'b1;
               cnt_n     = CNT_W'(T_RFC - 1);
               state_n   = REF_WAIT;
            end else if (pend_valid || req) begin
               start_pend = pend_valid;
               start_new  = !pend_valid;
               cmd_n      = CMD_ACT;
               ba_n       = sel_bank;
               a_n        = sel_row;
               cnt_n      = CNT_W'(T_RCD - 1);
               state_n    = ACT;
            end
         end
         ACT: if (cnt == '0) begin
            a_n                 = '0;
            a_n[COL_BITS-1:0]   = cur_col;
            a_n[10]             = 1'b1;
            if (cur_we) begin
               cmd_n   = CMD_WRITE;
               dq_oe_n = 1'b1;
               dqm_n   = cur_wm;
            end else begin
               cmd_n   = CMD_READ;
               dqm_n   = 2'b00;
            end
            state_n = RW;
         end
         RW: begin
            if (cur_we) begin
               ack_n   = 1'b1;
               dqm_n   = 2'b11;
               cnt_n   = CNT_W'(T_WR + T_RP - 1);
               state_n = WR_REC;
            end else begin
               cnt_n   = CNT_W'(CAS_LATENCY - 1);
               state_n = RD_WAIT;
            end
         end
         RD_WAIT: if (cnt == '0) begin
            rd_cap  = 1'b1;
            ack_n   = 1'b1;
            dqm_n   = 2'b11;
            cnt_n   = CNT_W'(T_RP - 1);
            state_n = WR_REC;
         end
         WR_REC: if (cnt == '0) state_n = IDLE;
         REF_WAIT: if (cnt == '0) state_n = IDLE;
         default: state_n = INIT_WAIT;
      endcase
   end

`ifdef SDRAM_REQ_QUEUE_EN
   assign pend_load = init_done && req && !start_new && (!pend_valid || start_pend);
`else
   // Only a req that loses to a forced refresh in IDLE is held over.
   assign pend_load = init_done && req && (state == IDLE) && force_ref && !pend_valid;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= INIT_WAIT;
         cnt        <= CNT_W'(INIT_CYCLES);
         cmd_q      <= CMD_NOP;
         ba_q       <= '0;
         a_q        <= '0;
         dqm_q      <= 2'b11;
         cke_q      <= 1'b0;
         dq_oe      <= 1'b0;
         dq_out     <= '0;
         data_read  <= '0;
         ack        <= 1'b0;
         init_done  <= 1'b0;
         ref_cnt    <= '0;
         cur_we     <= 1'b0;
         cur_col    <= '0;
         cur_wm     <= 2'b11;
         cur_data   <= '0;
         pend_valid <= 1'b0;
         pend_we    <= 1'b0;
         pend_addr  <= '0;
         pend_wm    <= 2'b11;
         pend_data  <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         cmd_q  <= cmd_n;
         ba_q   <= ba_n;
         a_q    <= a_n;
         dqm_q  <= dqm_n;
         cke_q  <= 1'b1;
         dq_oe  <= dq_oe_n;
         dq_out <= cur_data;
         ack    <= ack_n;
         if (done_set) init_done <= 1'b1;
         if (rd_cap) data_read <= sdram_dq;
         if (ref_issue) ref_cnt <= '0;
         else if (init_done && ref_cnt != REF_MAX) ref_cnt <= ref_cnt + 1'b1;
         if (start_new || start_pend) begin
            cur_we   <= sel_we;
            cur_col  <= sel_col;
            cur_wm   <= sel_wm;
            cur_data <= sel_data;
         end
         if (pend_load) begin
            pend_valid <= 1'b1;
            pend_we    <= we;
            pend_addr  <= address;
            pend_wm    <= wm;
            pend_data  <= data_write;
         end else if (start_pend) begin
            pend_valid <= 1'b0;
         end
      end
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
   assign sdram_cke = cke_q;
   assign sdram_ba  = ba_q;
   assign sdram_a   = a_q;
   assign sdram_dqm = dqm_q;
   assign sdram_dq  = dq_oe ? dq_out : 16'hzzzz;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb/tb_sdram_ctrl.sv - directed self-checking bench for sdram_ctrl
module tb_sdram_ctrl;
   localparam logic [3:0] C_NOP = 4'b1111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_MRS = 4'b0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        refresh = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [21:0] address = '0;
   logic [1:0]  wm = '0;
   logic [15:0] data_write = '0;
   logic [15:0] data_read;
   logic        ack, busy, init_done;
   logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [11:0] sdram_a;
   logic [1:0]  sdram_dqm;
   wire  [15:0] sdram_dq;

   logic [15:0] dq_drv = '0;
   logic        dq_drv_en = 1'b0;
   logic [1:0]  rd_hist = '0;
   logic [15:0] rd_word = '0;
   int          n_cmp = 0;
   int          n_err = 0;

   sdram_ctrl dut (
      .clk(clk), .rst_n(rst_n), .refresh(refresh), .req(req), .we(we),
      .address(address), .wm(wm), .data_write(data_write), .data_read(data_read),
      .ack(ack), .busy(busy), .init_done(init_done), .sdram_cke(sdram_cke),
      .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
      .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
      .sdram_dqm(sdram_dqm), .sdram_dq(sdram_dq)
   );

   always #5 clk = ~clk;
   assign sdram_dq = dq_drv_en ? dq_drv : 16'hzzzz;

   function automatic logic [3:0] cur_cmd();
      return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
   endfunction

   // Chip model: drives rd_word in the CL=2 data cycle after a READ.
   always @(negedge clk) begin
      dq_drv_en = rd_hist[1];
      dq_drv    = rd_word;
      rd_hist   = {rd_hist[0], (cur_cmd() == C_RD)};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cmd(input int budget, output int dly);
      dly = 0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         dly++;
         if (cur_cmd() != C_NOP) break;
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy) break;
         cyc();
      end
      check("wait_idle", busy, 1'b0);
   endtask

   initial begin
      int   dly;
      int   cnt;
      int   n_act;
      logic flag;
      logic ack_seen;

      repeat (3) cyc();
      check("rst_cke", sdram_cke, 1'b0);
      check("rst_cmd", cur_cmd(), C_NOP);
      check("rst_ba", sdram_ba, 2'd0);
      check("rst_a", sdram_a, 12'h000);
      check("rst_dqm", sdram_dqm, 2'b11);
      check("rst_dq_z", (sdram_dq === 16'hzzzz), 1'b1);
      check("rst_data_read", data_read, 16'h0000);
      check("rst_ack", ack, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_init_done", init_done, 1'b0);

      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 25000; i++) begin
         cyc();
         if (cur_cmd() != C_NOP) break;
         if (sdram_cke) cnt++;
      end
      check("init_nop_cycles", cnt, 20000);
      check("init_pre_cmd", cur_cmd(), C_PRE);
      check("init_pre_a10", sdram_a[10], 1'b1);
      wait_cmd(50, dly);
      check("init_ref1_cmd", cur_cmd(), C_REF);
      check("init_ref1_dly", dly, 2);
      wait_cmd(50, dly);
      check("init_ref2_cmd", cur_cmd(), C_REF);
      check("init_ref2_dly", dly, 7);
      wait_cmd(50, dly);
      check("init_mrs_cmd", cur_cmd(), C_MRS);
      check("init_mrs_dly", dly, 7);
      check("init_mrs_a", sdram_a, 12'h220);
      cyc();
      check("init_done_early", init_done, 1'b0);
      cyc();
      check("init_done", init_done, 1'b1);
      check("init_idle", busy, 1'b0);

      // Hint refresh in IDLE; this AREF also anchors the deadline below.
      refresh = 1'b1;
      cyc();
      refresh = 1'b0;
      check("hint_ref_cmd", cur_cmd(), C_REF);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         cnt++;
         cyc();
      end
      check("hint_busy_cycles", cnt, 7);

      // Req lands in the cycle the refresh counter reaches 750.
      repeat (743) cyc();
      req = 1'b1; we = 1'b0; address = {12'h0F0, 2'd3, 8'h12}; rd_word = 16'h1357;
      cyc();
      req = 1'b0;
      check("deadline_ref_first", cur_cmd(), C_REF);
      wait_cmd(40, dly);
      check("deadline_act_cmd", cur_cmd(), C_ACT);
      check("deadline_act_dly", dly, 8);
      check("deadline_act_ba", sdram_ba, 2'd3);
      check("deadline_act_row", sdram_a, 12'h0F0);
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (ack) break;
      end
      check("deadline_ack", ack, 1'b1);
      check("deadline_data", data_read, 16'h1357);
      wait_idle(20);

      // Read: row 123, bank 1, col 45.
      cyc();
      req = 1'b1; we = 1'b0; address = {12'h123, 2'd1, 8'h45}; rd_word = 16'hBEEF;
      cyc();
      req = 1'b0;
      check("rd_act_cmd", cur_cmd(), C_ACT);
      check("rd_act_ba", sdram_ba, 2'd1);
      check("rd_act_row", sdram_a, 12'h123);
      flag = ack;
      cyc();
      flag |= ack;
      cyc();
      flag |= ack;
      check("rd_cmd", cur_cmd(), C_RD);
      check("rd_a", sdram_a, 12'h445);
      check("rd_dqm_cmd", sdram_dqm, 2'b00);
      cyc();
      flag |= ack;
      cyc();
      flag |= ack;
      check("rd_dqm_data", sdram_dqm, 2'b00);
      check("rd_ack_early", flag, 1'b0);
      cyc();
      check("rd_ack", ack, 1'b1);
      check("rd_data", data_read, 16'hBEEF);
      cyc();
      check("rd_ack_pulse", ack, 1'b0);
      check("rd_data_hold", data_read, 16'hBEEF);
      check("rd_busy_7", busy, 1'b1);
      cyc();
      check("rd_idle_8", busy, 1'b0);

      // Write with low byte masked.
      req = 1'b1; we = 1'b1; wm = 2'b01; data_write = 16'hA5A5; address = {12'h3FF, 2'd2, 8'hA7};
      cyc();
      req = 1'b0; data_write = 16'h0000; wm = 2'b11;
      check("wr_act_cmd", cur_cmd(), C_ACT);
      check("wr_act_ba", sdram_ba, 2'd2);
      check("wr_act_row", sdram_a, 12'h3FF);
      cyc();
      check("wr_dq_z_before", (sdram_dq === 16'hzzzz), 1'b1);
      cyc();
      check("wr_cmd", cur_cmd(), C_WR);
      check("wr_dq", sdram_dq, 16'hA5A5);
      check("wr_dqm", sdram_dqm, 2'b01);
      check("wr_a", sdram_a, 12'h4A7);
      check("wr_ack_early", ack, 1'b0);
      cyc();
      check("wr_ack", ack, 1'b1);
      check("wr_dq_z_after", (sdram_dq === 16'hzzzz), 1'b1);
      repeat (3) cyc();
      check("wr_busy_7", busy, 1'b1);
      cyc();
      check("wr_idle_8", busy, 1'b0);

      // Hint while a read is in flight is dropped.
      req = 1'b1; we = 1'b0; address = {12'h001, 2'd0, 8'h00}; rd_word = 16'h0F0F;
      cyc();
      req = 1'b0;
      cyc();
      refresh = 1'b1;
      cyc();
      refresh = 1'b0;
      flag = 1'b0;
      ack_seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         cyc();
         flag |= (cur_cmd() == C_REF);
         ack_seen |= ack;
      end
      check("busy_hint_no_ref", flag, 1'b0);
      check("busy_hint_read_ack", ack_seen, 1'b1);
      check("busy_hint_data", data_read, 16'h0F0F);

      // Second req two cycles after the first.
      n_act = 0;
      req = 1'b1; we = 1'b0; address = {12'h0AA, 2'd1, 8'h01}; rd_word = 16'h2468;
      cyc();
      req = 1'b0;
      if (cur_cmd() == C_ACT) n_act++;
      cyc();
      if (cur_cmd() == C_ACT) n_act++;
      req = 1'b1; we = 1'b1; wm = 2'b00; data_write = 16'h55AA; address = {12'h0BB, 2'd2, 8'h02};
      cyc();
      req = 1'b0;
      if (cur_cmd() == C_ACT) n_act++;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (cur_cmd() == C_ACT) n_act++;
      end
`ifdef SDRAM_REQ_QUEUE_EN
      check("second_req_act_count", n_act, 2);
`else
      check("second_req_act_count", n_act, 1);
`endif
      wait_idle(20);

      // Reset in the middle of a read.
      req = 1'b1; we = 1'b0; address = {12'h050, 2'd0, 8'h10}; rd_word = 16'hDEAD;
      cyc();
      req = 1'b0;
      repeat (3) cyc();
      check("mid_rd_dqm", sdram_dqm, 2'b00);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cke", sdram_cke, 1'b0);
      check("mid_rst_cmd", cur_cmd(), C_NOP);
      check("mid_rst_dqm", sdram_dqm, 2'b11);
      check("mid_rst_init_done", init_done, 1'b0);
      flag = 1'b0;
      repeat (3) begin
         cyc();
         flag |= ack;
      end
      rst_n = 1'b1;
      repeat (6) begin
         cyc();
         flag |= ack;
      end
      check("mid_rst_no_ack", flag, 1'b0);
      check("mid_rst_data", data_read, 16'h0000);
      check("mid_rst_cke_back", sdram_cke, 1'b1);
      check("mid_rst_busy", busy, 1'b1);
      check("mid_rst_restart_nop", cur_cmd(), C_NOP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
